ccd_phase_sequencer: RTL

Wishbone-configured timing generator that drives the four CCD clock phases (phi_l1, phi_l2, phi_r, phi_p) through a complete frame readout. For each line it runs a two-step line-shift pulse, then NPIX reset/pixel pulse pairs. Each pixel pair ends with a one-cycle ADC sample strobe. It replaces direct software bit-banging of the phase register and sits on the caravel Wishbone bus at its own base address.

---
 rtl/ccd_phase_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ccd_phase_sequencer.sv
// ccd_phase_sequencer: Wishbone-configured generator for the four CCD clock phases.
// Each line gets a two-step line shift followed by NPIX reset/pixel pulse pairs.
module ccd_phase_sequencer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          CNT_W        = 12,
    parameter int          DIV_W        = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        o_phi_l1,
    output logic        o_phi_l2,
    output logic        o_phi_r,
    output logic        o_phi_p,
    output logic        o_sample,
    output logic        o_busy,
    output logic        o_irq
);
    typedef enum logic [2:0] {IDLE, LINE_A, LINE_B, PIX_R, PIX_P, DONE} state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DIV    = 3'd1;
    localparam logic [2:0] REG_NPIX   = 3'd2;
    localparam logic [2:0] REG_NLINES = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    state_t state, state_next;

    logic [DIV_W-1:0] div_reg, div_cnt;
    logic [CNT_W-1:0] npix_reg, nlines_reg, pix_cnt, line_cnt;
    logic [CNT_W-1:0] pix_inc, line_inc;
    logic             cont_reg, done_reg, start_pulse, abort_pulse;

    logic [31:0] offset;
    logic [2:0]  word;
    logic        hit, take, wr;
    logic [31:0] rdata;
    logic        tick, pix_last, busy, frame_start;
    logic        unused_bits;

    assign offset      = wbs_adr_i - BASE_ADDRESS;
    assign word        = offset[4:2];
    assign hit         = (offset[31:5] == 27'd0) && (offset[1:0] == 2'b00) && (word <= REG_STATUS);
    assign take        = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && hit;
    assign wr          = take && wbs_we_i;
    assign unused_bits = ^wbs_dat_i;

    assign tick     = (div_cnt == div_reg);
    assign pix_inc  = pix_cnt + CNT_W'(1);
    assign line_inc = line_cnt + CNT_W'(1);
    assign pix_last = (pix_inc >= npix_reg);
    assign busy     = (state != IDLE) && (state != DONE);
    assign o_busy   = busy;

    always_comb begin
        rdata = 32'd0;
        case (word)
            REG_CTRL:   rdata[2] = cont_reg;
            REG_DIV:    rdata[DIV_W-1:0] = div_reg;
            REG_NPIX:   rdata[CNT_W-1:0] = npix_reg;
            REG_NLINES: rdata[CNT_W-1:0] = nlines_reg;
            REG_STATUS: begin
                rdata[0]          = busy;
                rdata[1]          = done_reg;
                rdata[16 +: CNT_W] = line_cnt;
            end
            default:    rdata = 32'd0;
        endcase
    end

    // Phase outputs decode straight from the state register; a frame start
    // with an empty geometry skips every phase state and lands in DONE.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        o_phi_l1    = 1'b0;
        o_phi_l2    = 1'b0;
        o_phi_r     = 1'b0;
        o_phi_p     = 1'b0;
        o_sample    = 1'b0;
        o_irq       = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) frame_start = 1'b1;
            end
            LINE_A: begin
                o_phi_l1 = 1'b1;
                if (tick) state_next = LINE_B;
            end
            LINE_B: begin
                o_phi_l2 = 1'b1;
                if (tick) state_next = PIX_R;
            end
            PIX_R: begin
                o_phi_r = 1'b1;
                if (tick) state_next = PIX_P;
            end
            PIX_P: begin
                o_phi_p = 1'b1;
                if (tick) begin
                    o_sample = 1'b1;
                    if (!pix_last)                  state_next = PIX_R;
                    else if (line_inc < nlines_reg) state_next = LINE_A;
                    else                            state_next = DONE;
                end
            end
            DONE: begin
                o_irq = 1'b1;
                if (cont_reg || start_pulse) frame_start = 1'b1;
                else                         state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (frame_start)
            state_next = (npix_reg == '0 || nlines_reg == '0) ? DONE : LINE_A;
        if (abort_pulse) begin
            state_next  = IDLE;
            frame_start = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'd0;
            start_pulse <= 1'b0;
            abort_pulse <= 1'b0;
            cont_reg    <= 1'b0;
            done_reg    <= 1'b0;
            div_reg     <= '0;
            div_cnt     <= '0;
            npix_reg    <= '0;
            nlines_reg  <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
        end else begin
            wbs_ack_o <= take;
            if (take) wbs_dat_o <= rdata;
            start_pulse <= wr && (word == REG_CTRL) && wbs_dat_i[0] && !wbs_dat_i[1];
            abort_pulse <= wr && (word == REG_CTRL) && wbs_dat_i[1];

            // Geometry and mode stay frozen for the duration of a frame.
            if (wr && !busy) begin
                case (word)
                    REG_CTRL:   cont_reg   <= wbs_dat_i[2];
                    REG_DIV:    div_reg    <= wbs_dat_i[DIV_W-1:0];
                    REG_NPIX:   npix_reg   <= wbs_dat_i[CNT_W-1:0];
                    REG_NLINES: nlines_reg <= wbs_dat_i[CNT_W-1:0];
                    default:    ;
                endcase
            end

            state <= state_next;
            if (state_next != state || state == IDLE) div_cnt <= '0;
            else                                      div_cnt <= div_cnt + DIV_W'(1);

            if (frame_start) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (state == PIX_P && tick) begin
                if (!pix_last) begin
                    pix_cnt <= pix_inc;
                end else begin
                    pix_cnt  <= '0;
                    line_cnt <= line_inc;
                end
            end

            // Setting done in DONE is ordered last so it wins over a W1C clear.
            if (frame_start) done_reg <= 1'b0;
            if (wr && word == REG_STATUS && wbs_dat_i[1]) done_reg <= 1'b0;
            if (state == DONE && !abort_pulse) done_reg <= 1'b1;
        end
    end
endmodule
